// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and default geometry for the systolic column
package systolic_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  localparam int ROWS_DEF    = 8;
  localparam int PE_LAT_DEF  = 3;
  localparam int VEC_W_DEF   = 10;
  localparam int WADDR_W_DEF = 8;
  localparam int DATA_W      = 16;
  localparam int ACC_W       = 32;
endpackage

// File: rtl/valid_delay.sv
// valid_delay: DEPTH-cycle 1-bit shift register with synchronous clear
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;
  // shift in d each cycle; clr flushes every in-flight bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= clr ? '0 : (sr << 1) | DEPTH'(d);
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-stationary column sequencer; optional busy-cycle counter under SYSTOLIC_CTRL_PERF_EN
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int PE_LAT  = PE_LAT_DEF,
  parameter int VEC_W   = VEC_W_DEF,
  parameter int WADDR_W = WADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [VEC_W-1:0]   num_vec,
  output logic               busy,
  output logic               done,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_rd_addr,
  output logic [ROWS-1:0]    w_load,
  output logic               act_rd_en,
  output logic [VEC_W-1:0]   act_rd_addr,
  output logic [ROWS-1:0]    act_valid_sk,
  output logic               out_valid,
  output logic [31:0]        perf_cycles
);
  localparam int DRAIN_LEN = ROWS * PE_LAT + 1;
  state_t state, state_n;
  logic [VEC_W-1:0] nv;
  logic [31:0] cnt;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: phase lengths come from cnt; abort overrides everything
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = (num_vec != '0) ? LOAD_W : DONE;
      LOAD_W:  if (cnt == 32'(ROWS - 1)) state_n = STREAM;
      STREAM:  if (cnt == 32'(nv) - 32'd1) state_n = DRAIN;
      DRAIN:   if (cnt == 32'(DRAIN_LEN - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  // phase counter restarts at every state change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 32'd1;
  // job length captured on the accepted start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nv <= '0;
    else if (state == IDLE && start) nv <= num_vec;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign w_rd_en     = state == LOAD_W;
  assign act_rd_en   = state == STREAM;
  assign w_rd_addr   = w_rd_en ? cnt[WADDR_W-1:0] : '0;
  assign act_rd_addr = act_rd_en ? cnt[VEC_W-1:0] : '0;
  // weight arrives one cycle after its read; latch it into the matching row
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) w_load <= '0;
    else w_load <= (w_rd_en && !abort) ? ROWS'(1) << cnt : '0;
  for (genvar r = 0; r < ROWS; r++) begin : g_sk
    valid_delay #(.DEPTH(1 + r * PE_LAT)) u_sk (
      .clk(clk), .rst_n(rst_n), .clr(abort), .d(act_rd_en), .q(act_valid_sk[r])
    );
  end
  valid_delay #(.DEPTH(1 + ROWS * PE_LAT)) u_out (
    .clk(clk), .rst_n(rst_n), .clr(abort), .d(act_rd_en), .q(out_valid)
  );
`ifdef SYSTOLIC_CTRL_PERF_EN
  // busy-cycle counter: cleared on accepted start, saturating, held while idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_cycles <= '0;
    else if (state == IDLE && start) perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench for systolic_ctrl at ROWS=4, PE_LAT=3
module tb_systolic_ctrl;
  localparam int R = 4;
  localparam int L = 3;
  localparam int VW = 10;
  localparam int AW = 8;
  typedef struct packed {
    logic busy, done, w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic [R-1:0] w_load;
    logic act_rd_en;
    logic [VW-1:0] act_rd_addr;
    logic [R-1:0] act_valid_sk;
    logic out_valid;
  } obs_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [VW-1:0] num_vec = '0;
  logic busy, done, w_rd_en, act_rd_en, out_valid;
  logic [AW-1:0] w_rd_addr;
  logic [R-1:0] w_load, act_valid_sk;
  logic [VW-1:0] act_rd_addr;
  logic [31:0] perf_cycles;
  int checks = 0, errors = 0;
  obs_t sb[$];
  obs_t obs;
  systolic_ctrl #(.ROWS(R), .PE_LAT(L), .VEC_W(VW), .WADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_load(w_load),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_valid_sk(act_valid_sk),
    .out_valid(out_valid), .perf_cycles(perf_cycles)
  );
  always #5 clk = ~clk;
  assign obs = '{busy, done, w_rd_en, w_rd_addr, w_load, act_rd_en, act_rd_addr, act_valid_sk, out_valid};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // expected outputs k cycles after start was sampled, for an n-vector job aborted in cycle ab (0 = none)
  function automatic obs_t model(input int k, input int n, input int ab);
    obs_t e;
    int last;
    e = '0;
    last = (n == 0) ? 1 : R + n + R * L + 2;
    if (ab > 0 && k > ab) return e;
    e.busy = k >= 1 && k <= last;
    e.done = k == last;
    if (n != 0) begin
      e.w_rd_en = k >= 1 && k <= R;
      e.w_rd_addr = e.w_rd_en ? AW'(k - 1) : '0;
      e.w_load = (k >= 2 && k <= R + 1) ? R'(1 << (k - 2)) : '0;
      e.act_rd_en = k > R && k <= R + n;
      e.act_rd_addr = e.act_rd_en ? VW'(k - R - 1) : '0;
      for (int r = 0; r < R; r++) e.act_valid_sk[r] = k >= R + 2 + r * L && k <= R + n + 1 + r * L;
      e.out_valid = k >= R + 2 + R * L && k <= R + n + 1 + R * L;
    end
    return e;
  endfunction
  // drive one job; st2 re-asserts start mid-job, ab aborts in that cycle
  task automatic run_job(input int n, input int st2, input int ab);
    int total, exp_perf;
    obs_t e;
    total = (ab > 0) ? ab + 1 : ((n == 0) ? 1 : R + n + R * L + 2) + 2;
    exp_perf = 0;
    for (int k = 1; k <= total; k++) begin
      e = model(k, n, ab);
      sb.push_back(e);
      exp_perf += int'(e.busy);
    end
    @(negedge clk);
    start = 1;
    num_vec = VW'(n);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      check($sformatf("job n=%0d k=%0d", n, k), 64'(obs), 64'(sb.pop_front()));
      start = k == st2;
      num_vec = (k == st2) ? VW'(7) : VW'(n);
      abort = k == ab;
    end
    start = 0;
    abort = 0;
`ifdef SYSTOLIC_CTRL_PERF_EN
    check($sformatf("perf n=%0d", n), 64'(perf_cycles), 64'(exp_perf));
`else
    check($sformatf("perf n=%0d", n), 64'(perf_cycles), 64'(0));
`endif
  endtask
  initial begin
    start = 1;
    num_vec = VW'(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset outputs", 64'(obs), 64'(0));
      check("reset perf", 64'(perf_cycles), 64'(0));
    end
    start = 0;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle after reset", 64'(obs), 64'(0));
    end
    run_job(3, 0, 0);
    run_job(0, 0, 0);
    run_job(3, 6, 0);
    run_job(3, 0, 6);
    run_job(3, 0, 0);
    run_job(1, 0, 0);
    run_job(5, 0, 2);
    run_job(5, 0, 14);
    run_job(6, 0, 0);
    @(negedge clk);
    start = 1;
    num_vec = VW'(4);
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2 rst_n = 0;
    #1 check("async reset", 64'(obs), 64'(0));
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("no job after reset", 64'({busy, done}), 64'(0));
    end
    check("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter ROWS, default 8: number of PE rows in the weight-stationary column.
REQ-002 Parameter PE_LAT, default 3: pipeline latency of one PE, in cycles.
REQ-003 Parameter VEC_W, default 10: width of the vector-count and activation-address fields.
REQ-004 Parameter WADDR_W, default 8: width of the weight-memory address.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a job; sampled in IDLE only.
- abort  in  1  synchronous cancel of the current job.
- num_vec  in  VEC_W  activation vectors in the job; captured on the accepted start.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at job completion.
- w_rd_en  out  1  weight-memory read strobe; memory read latency is 1 cycle.
- w_rd_addr  out  WADDR_W  weight address.
- w_load  out  ROWS  one-hot per-row PE mode (weight-latch) enable.
- act_rd_en  out  1  activation-memory read strobe; memory read latency is 1 cycle.
- act_rd_addr  out  VEC_W  activation address.
- act_valid_sk  out  ROWS  per-row skewed activation valid.
- out_valid  out  1  column-bottom partial sum valid.
- perf_cycles  out  32  busy-cycle count (see Configuration).

Function
REQ-006 FSM states SHALL be IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-007 In IDLE, start=1 with num_vec!=0 SHALL move to LOAD_W and capture num_vec.
REQ-008 In IDLE, start=1 with num_vec==0 SHALL move straight to DONE; no reads are issued.
REQ-009 start SHALL be ignored in every state other than IDLE.
REQ-010 LOAD_W SHALL last exactly ROWS cycles with w_rd_en=1 and w_rd_addr=0..ROWS-1, one address per cycle; it then moves to STREAM.
REQ-011 w_load[r] SHALL be high for exactly one cycle, the cycle after w_rd_addr=r is issued; at most one bit of w_load is high in any cycle.
REQ-012 STREAM SHALL last exactly num_vec cycles with act_rd_en=1 and act_rd_addr=0..num_vec-1; it then moves to DRAIN.
REQ-013 act_valid_sk[r] SHALL equal act_rd_en delayed by 1+r*PE_LAT cycles.
REQ-014 out_valid SHALL equal act_rd_en delayed by 1+ROWS*PE_LAT cycles.
REQ-015 DRAIN SHALL last exactly ROWS*PE_LAT+1 cycles, so the last out_valid falls in the final DRAIN cycle; it then moves to DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-017 busy SHALL be high in all states except IDLE.
REQ-018 abort=1 in any non-IDLE state SHALL, on the next edge, force IDLE and clear all delay lines, strobes and w_load; done is not asserted.
REQ-019 abort SHALL take priority over every other transition.
REQ-020 Counters SHALL be sized so that num_vec = 2^VEC_W-1 completes without wrap.

Reset
REQ-021 rst_n=0 SHALL asynchronously force the FSM to IDLE and clear all counters and delay lines.
REQ-022 During reset, all outputs SHALL be 0, including perf_cycles.
REQ-023 Reset asserted mid-job SHALL discard the job; no done pulse follows reset release.

Configuration
REQ-024 The feature macro SHALL be SYSTOLIC_CTRL_PERF_EN.
REQ-025 With SYSTOLIC_CTRL_PERF_EN defined:
- perf_cycles clears on an accepted start.
- It increments on every busy cycle.
- It holds its value after done until the next accepted start.
- It saturates at 2^32-1.
REQ-026 Without the macro, perf_cycles SHALL be tied to 0 and no counter logic is generated.

Structure
REQ-027 Package systolic_pkg SHALL hold the FSM state enum and the default ROWS, PE_LAT and DATA/PORT widths shared with the PE array.
REQ-028 Sub-module valid_delay SHALL be a parameterized-depth, reset-clearable 1-bit shift register.
- It is used for every act_valid_sk bit and for out_valid.
- The clear input is driven by abort.

Verification (ROWS=4, PE_LAT=3; start sampled at cycle 0)
REQ-029 Reset: hold rst_n=0 with start=1 -> all outputs 0; FSM stays IDLE after release until a new start.
REQ-030 Normal job, start with num_vec=3:
- w_rd_addr 0..3 in cycles 1-4; w_load = 0001, 0010, 0100, 1000 in cycles 2-5.
- act_rd_addr 0..2 in cycles 5-7; act_valid_sk[0] in cycles 6-8; act_valid_sk[3] in cycles 15-17.
- out_valid in cycles 18-20; done in cycle 21; busy high in cycles 1-21.
REQ-031 Zero-length job, start with num_vec=0 -> done in cycle 1; busy only in cycle 1; no w_rd_en or act_rd_en.
REQ-032 Start while busy, second start in cycle 6 of the REQ-030 job -> ignored; timing identical to REQ-030.
REQ-033 Abort in cycle 6 -> IDLE in cycle 7.
- All valids are 0 from cycle 7 onward; no done.
- A new start in cycle 8 runs cleanly.
REQ-034 Perf, REQ-030 job with SYSTOLIC_CTRL_PERF_EN -> perf_cycles=21 after done; without the macro, perf_cycles=0 throughout.
